robocup_top: RTL and testbench

Top-level FPGA block of the robot controller. Sits between the MCU multiplexed 8-bit bus and the peripherals:
- five BLDC motor drivers
- radio serial configuration
- UART passthrough
- kicker/chipper
- board I/O (LEDs, button, switches).

All MCU access goes through a small register file.

---
 rtl/robocup_top.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_robocup_top.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/robocup_top.sv
// Robot controller top: MCU register bus, five BLDC drivers, radio serializer,
// kicker and board I/O. Optional per-motor hall counters via HALL_COUNTER_EN.
module robocup_top #(
    parameter int PWM_BITS  = 8,
    parameter int KICK_UNIT = 256,
    parameter int SER_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       led0,
    output logic       led1,
    input  logic       tx_mcu,
    output logic       rx_mcu,
    output logic       tx_radio,
    input  logic       rx_radio,
    output logic       rx_pdn,
    output logic       rx_ssdata,
    output logic       rx_ssclk,
    input  logic       tx_pdn,
    output logic       tx_ssdata,
    output logic       tx_ssclk,
    input  logic       ale,
    input  logic       read,
    input  logic       write,
    inout  wire  [7:0] data,
    input  logic       m1hall_a,
    input  logic       m1hall_b,
    input  logic       m1hall_c,
    input  logic       m2hall_a,
    input  logic       m2hall_b,
    input  logic       m2hall_c,
    input  logic       m3hall_a,
    input  logic       m3hall_b,
    input  logic       m3hall_c,
    input  logic       m4hall_a,
    input  logic       m4hall_b,
    input  logic       m4hall_c,
    input  logic       m5hall_a,
    input  logic       m5hall_b,
    input  logic       m5hall_c,
    output logic       m1a_h,
    output logic       m1a_l,
    output logic       m1b_h,
    output logic       m1b_l,
    output logic       m1c_h,
    output logic       m1c_l,
    output logic       m2a_h,
    output logic       m2a_l,
    output logic       m2b_h,
    output logic       m2b_l,
    output logic       m2c_h,
    output logic       m2c_l,
    output logic       m3a_h,
    output logic       m3a_l,
    output logic       m3b_h,
    output logic       m3b_l,
    output logic       m3c_h,
    output logic       m3c_l,
    output logic       m4a_h,
    output logic       m4a_l,
    output logic       m4b_h,
    output logic       m4b_l,
    output logic       m4c_h,
    output logic       m4c_l,
    output logic       m5a_h,
    output logic       m5a_l,
    output logic       m5b_h,
    output logic       m5b_l,
    output logic       m5c_h,
    output logic       m5c_l,
    input  logic       button,
    input  logic [3:0] switch,
    output logic       ant_a,
    output logic       ant_b,
    input  logic       charge_done,
    output logic       charge,
    output logic       kick,
    output logic       chip,
    input  logic       tx_cts
);

    localparam int DW = $clog2(SER_DIV);
    localparam int KW = 7 + $clog2(KICK_UNIT) + 1;

    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [2:0] wr_sync;
    logic       wr_commit;
    logic [7:0] rdata;

    logic [4:0]          mask_q;
    logic [PWM_BITS-1:0] duty_q [5];
    logic [1:0]          kctl_q;
    logic [7:0]          cfg_q;

    logic          ser_busy;
    logic [7:0]    ser_sh;
    logic [2:0]    ser_bit;
    logic [DW-1:0] ser_div;

    logic [1:0]    cd_sync;
    logic          firing;
    logic          chip_sel;
    logic [KW-1:0] kick_cnt;

    logic [21:0] led_cnt;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [2:0]          hall_raw [5];
    logic [2:0]          hall_s1  [5];
    logic [2:0]          hall_s2  [5];
    logic [5:0]          gate_q   [5];

    assign hall_raw[0] = {m1hall_a, m1hall_b, m1hall_c};
    assign hall_raw[1] = {m2hall_a, m2hall_b, m2hall_c};
    assign hall_raw[2] = {m3hall_a, m3hall_b, m3hall_c};
    assign hall_raw[3] = {m4hall_a, m4hall_b, m4hall_c};
    assign hall_raw[4] = {m5hall_a, m5hall_b, m5hall_c};

    assign {m1a_h, m1a_l, m1b_h, m1b_l, m1c_h, m1c_l} = gate_q[0];
    assign {m2a_h, m2a_l, m2b_h, m2b_l, m2c_h, m2c_l} = gate_q[1];
    assign {m3a_h, m3a_l, m3b_h, m3b_l, m3c_h, m3c_l} = gate_q[2];
    assign {m4a_h, m4a_l, m4b_h, m4b_l, m4c_h, m4c_l} = gate_q[3];
    assign {m5a_h, m5a_l, m5b_h, m5b_l, m5c_h, m5c_l} = gate_q[4];

    assign tx_radio  = tx_mcu;
    assign rx_mcu    = rx_radio;
    assign rx_pdn    = cfg_q[0];
    assign rx_ssdata = 1'b0;
    assign rx_ssclk  = 1'b0;
    assign led0      = charge_done;

    assign tx_ssdata = ser_busy & ser_sh[7];
    assign tx_ssclk  = ser_busy & (ser_div >= DW'(SER_DIV / 2));

    assign kick   = firing & ~chip_sel;
    assign chip   = firing & chip_sel;
    assign charge = kctl_q[0] & ~firing;

    // Sync starts at all-ones so the idle-high strobe never fakes an edge.
    assign wr_commit = wr_sync[1] & ~wr_sync[2];

    assign data = (!read && rst_n) ? rdata : 8'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_sync <= 3'b111;
        end else begin
            if (!ale) addr_q <= data;
            if (!write) wdata_q <= data;
            wr_sync <= {wr_sync[1:0], write};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            kctl_q <= '0;
            ant_a  <= 1'b0;
            ant_b  <= 1'b0;
            for (int i = 0; i < 5; i++) duty_q[i] <= '0;
        end else begin
            ant_a <= ~kctl_q[1];
            ant_b <= kctl_q[1];
            if (wr_commit && addr_q == 8'h00) mask_q <= wdata_q[4:0];
            if (wr_commit && addr_q == 8'h20) kctl_q <= wdata_q[1:0];
            for (int i = 0; i < 5; i++) begin
                if (wr_commit && addr_q == 8'(i + 1))
                    duty_q[i] <= PWM_BITS'(wdata_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q    <= '0;
            ser_busy <= 1'b0;
            ser_sh   <= '0;
            ser_bit  <= '0;
            ser_div  <= '0;
        end else if (!ser_busy) begin
            if (wr_commit && addr_q == 8'h10) begin
                cfg_q    <= wdata_q;
                ser_sh   <= wdata_q;
                ser_busy <= 1'b1;
                ser_bit  <= '0;
                ser_div  <= '0;
            end
        end else if (ser_div == DW'(SER_DIV - 1)) begin
            ser_div <= '0;
            ser_sh  <= {ser_sh[6:0], 1'b0};
            ser_bit <= ser_bit + 3'd1;
            if (ser_bit == 3'd7) ser_busy <= 1'b0;
        end else begin
            ser_div <= ser_div + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_sync  <= '0;
            firing   <= 1'b0;
            chip_sel <= 1'b0;
            kick_cnt <= '0;
        end else begin
            cd_sync <= {cd_sync[0], charge_done};
            if (!firing) begin
                if (wr_commit && addr_q == 8'h21 && cd_sync[1] &&
                    wdata_q[6:0] != 7'd0) begin
                    firing   <= 1'b1;
                    chip_sel <= wdata_q[7];
                    kick_cnt <= KW'(wdata_q[6:0]) * KW'(KICK_UNIT) - KW'(1);
                end
            end else if (kick_cnt == '0) begin
                firing <= 1'b0;
            end else begin
                kick_cnt <= kick_cnt - KW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_cnt <= '0;
            led1    <= 1'b0;
        end else begin
            led_cnt <= led_cnt + 22'd1;
            if (&led_cnt) led1 <= ~led1;
        end
    end

    // Gate word: {a_h, a_l, b_h, b_l, c_h, c_l}.
    function automatic logic [5:0] commutate(input logic [2:0] h,
                                             input logic       pwm);
        case (h)
            3'b101:  commutate = {pwm, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            3'b100:  commutate = {pwm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            3'b110:  commutate = {1'b0, 1'b0, pwm, 1'b0, 1'b0, 1'b1};
            3'b010:  commutate = {1'b0, 1'b1, pwm, 1'b0, 1'b0, 1'b0};
            3'b011:  commutate = {1'b0, 1'b1, 1'b0, 1'b0, pwm, 1'b0};
            3'b001:  commutate = {1'b0, 1'b0, 1'b0, 1'b1, pwm, 1'b0};
            default: commutate = 6'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            for (int i = 0; i < 5; i++) begin
                hall_s1[i] <= '0;
                hall_s2[i] <= '0;
                gate_q[i]  <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            for (int i = 0; i < 5; i++) begin
                hall_s1[i] <= hall_raw[i];
                hall_s2[i] <= hall_s1[i];
                gate_q[i]  <= mask_q[i] ?
                              commutate(hall_s2[i], pwm_cnt < duty_q[i]) : 6'b0;
            end
        end
    end

`ifdef HALL_COUNTER_EN
    logic [2:0] hall_prev [5];
    logic [7:0] hall_cnt  [5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                hall_prev[i] <= '0;
                hall_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                hall_prev[i] <= hall_s2[i];
                if (hall_s2[i] != hall_prev[i])
                    hall_cnt[i] <= hall_cnt[i] + 8'd1;
            end
        end
    end
`endif

    always_comb begin
        rdata = 8'h00;
        case (addr_q)
            8'h00: rdata = {3'b0, mask_q};
            8'h01: rdata = 8'(duty_q[0]);
            8'h02: rdata = 8'(duty_q[1]);
            8'h03: rdata = 8'(duty_q[2]);
            8'h04: rdata = 8'(duty_q[3]);
            8'h05: rdata = 8'(duty_q[4]);
`ifdef HALL_COUNTER_EN
            8'h08: rdata = hall_cnt[0];
            8'h09: rdata = hall_cnt[1];
            8'h0A: rdata = hall_cnt[2];
            8'h0B: rdata = hall_cnt[3];
            8'h0C: rdata = hall_cnt[4];
`endif
            8'h10: rdata = cfg_q;
            8'h12: rdata = {5'b0, tx_cts, tx_pdn, ser_busy};
            8'h20: rdata = {6'b0, kctl_q};
            8'h30: rdata = {3'b0, button, switch};
            default: rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_robocup_top.sv
// Directed + randomized bench for robocup_top against a behavioural model.
// Honours HALL_COUNTER_EN for the hall counter readback.
module tb_robocup_top;

    localparam int KU = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        tx_mcu, rx_radio, tx_pdn, ale, read, write;
    logic        button, charge_done, tx_cts;
    logic [3:0]  sw;
    logic [14:0] halls;
    wire  [29:0] gates;
    wire         led0, led1, rx_mcu, tx_radio, rx_pdn, rx_ssdata, rx_ssclk;
    wire         tx_ssdata, tx_ssclk, ant_a, ant_b, charge, kick, chip;
    wire  [7:0]  data;
    logic [7:0]  drv;
    logic        drv_en;

    assign data = drv_en ? drv : 8'bz;

    int n_cmp = 0;
    int n_fail = 0;
    int m1_changes = 0;
    int gcnt [5][6];
    int clash;
    logic [7:0] m_duty [5];
    logic [4:0] m_mask;

    robocup_top dut (
        .clk(clk), .rst_n(rst_n), .led0(led0), .led1(led1),
        .tx_mcu(tx_mcu), .rx_mcu(rx_mcu), .tx_radio(tx_radio),
        .rx_radio(rx_radio), .rx_pdn(rx_pdn), .rx_ssdata(rx_ssdata),
        .rx_ssclk(rx_ssclk), .tx_pdn(tx_pdn), .tx_ssdata(tx_ssdata),
        .tx_ssclk(tx_ssclk), .ale(ale), .read(read), .write(write),
        .data(data),
        .m1hall_a(halls[2]),  .m1hall_b(halls[1]),  .m1hall_c(halls[0]),
        .m2hall_a(halls[5]),  .m2hall_b(halls[4]),  .m2hall_c(halls[3]),
        .m3hall_a(halls[8]),  .m3hall_b(halls[7]),  .m3hall_c(halls[6]),
        .m4hall_a(halls[11]), .m4hall_b(halls[10]), .m4hall_c(halls[9]),
        .m5hall_a(halls[14]), .m5hall_b(halls[13]), .m5hall_c(halls[12]),
        .m1a_h(gates[5]),  .m1a_l(gates[4]),  .m1b_h(gates[3]),
        .m1b_l(gates[2]),  .m1c_h(gates[1]),  .m1c_l(gates[0]),
        .m2a_h(gates[11]), .m2a_l(gates[10]), .m2b_h(gates[9]),
        .m2b_l(gates[8]),  .m2c_h(gates[7]),  .m2c_l(gates[6]),
        .m3a_h(gates[17]), .m3a_l(gates[16]), .m3b_h(gates[15]),
        .m3b_l(gates[14]), .m3c_h(gates[13]), .m3c_l(gates[12]),
        .m4a_h(gates[23]), .m4a_l(gates[22]), .m4b_h(gates[21]),
        .m4b_l(gates[20]), .m4c_h(gates[19]), .m4c_l(gates[18]),
        .m5a_h(gates[29]), .m5a_l(gates[28]), .m5b_h(gates[27]),
        .m5b_l(gates[26]), .m5c_h(gates[25]), .m5c_l(gates[24]),
        .button(button), .switch(sw), .ant_a(ant_a), .ant_b(ant_b),
        .charge_done(charge_done), .charge(charge), .kick(kick),
        .chip(chip), .tx_cts(tx_cts)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] v);
        ale = 1'b0; drv_en = 1'b1; drv = a;
        tick(2);
        ale = 1'b1; drv = v; write = 1'b0;
        tick(2);
        write = 1'b1;
        tick(1);
        drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] v);
        ale = 1'b0; drv_en = 1'b1; drv = a;
        tick(2);
        ale = 1'b1; drv_en = 1'b0; read = 1'b0;
        tick(1);
        v = data;
        read = 1'b1;
        tick(1);
    endtask

    task automatic set_hall(input int m, input logic [2:0] v);
        if (m == 0 && halls[2:0] != v) m1_changes++;
        halls[3*m +: 3] = v;
        tick(4);
    endtask

    // Position in the six-step sequence, or -1 for an illegal code.
    function automatic int step_of(input logic [2:0] h);
        case (h)
            3'b101: return 0;
            3'b100: return 1;
            3'b110: return 2;
            3'b010: return 3;
            3'b011: return 4;
            3'b001: return 5;
            default: return -1;
        endcase
    endfunction

    task automatic measure_and_check(input string tag);
        int k, eh, el;
        clash = 0;
        for (int m = 0; m < 5; m++)
            for (int b = 0; b < 6; b++) gcnt[m][b] = 0;
        tick(6);
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            for (int m = 0; m < 5; m++) begin
                for (int b = 0; b < 6; b++)
                    if (gates[6*m+b]) gcnt[m][b]++;
                for (int p = 0; p < 3; p++)
                    if (gates[6*m+5-2*p] && gates[6*m+4-2*p]) clash++;
            end
        end
        check({tag, "_clash"}, clash, 0);
        for (int m = 0; m < 5; m++) begin
            k = step_of(halls[3*m +: 3]);
            for (int p = 0; p < 3; p++) begin
                eh = 0; el = 0;
                if (m_mask[m] && k >= 0) begin
                    if (p == k / 2) eh = int'(m_duty[m]);
                    if (p == ((k + 1) / 2 + 1) % 3) el = 256;
                end
                check($sformatf("%s_m%0d_p%0d_h", tag, m + 1, p),
                      gcnt[m][5-2*p], eh);
                check($sformatf("%s_m%0d_p%0d_l", tag, m + 1, p),
                      gcnt[m][4-2*p], el);
            end
        end
    endtask

    task automatic pulse(output int nk, output int nc, output int bad);
        nk = 0; nc = 0; bad = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (kick) nk++;
            if (chip) nc++;
            if ((kick || chip) && charge) bad++;
            if ((nk + nc) > 0 && !kick && !chip) break;
        end
    endtask

    initial begin
        logic [7:0] rv, cfgv, v;
        logic [2:0] seq [6];
        int nk, nc, bad, s, nbits;
        logic [7:0] got;
        logic prev;

        rst_n = 1'b0; tx_mcu = 1'b0; rx_radio = 1'b0; tx_pdn = 1'b0;
        ale = 1'b1; read = 1'b1; write = 1'b1; button = 1'b0;
        charge_done = 1'b0; tx_cts = 1'b0; sw = 4'h0; halls = '0;
        drv = 8'h3C; drv_en = 1'b1;
        tick(3);
        check("rst_gates", gates, 30'd0);
        check("rst_bus_hiz", data, 8'h3C);
        check("rst_outs", {led0, led1, kick, chip, charge, tx_ssdata,
                           tx_ssclk, rx_pdn, ant_a, ant_b}, 10'd0);
        drv_en = 1'b0;
        rst_n = 1'b1;
        tick(2);
        bus_read(8'h12, rv);
        check("status_reset", rv, 8'h00);

        tx_pdn = 1'b1;
        for (int r = 0; r < 2; r++) begin
            cfgv = (r == 0) ? 8'hE5 : 8'($urandom);
            bus_write(8'h10, cfgv);
            nbits = 0; got = '0; prev = 1'b0;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (tx_ssclk && !prev) begin
                    if (nbits < 8) got[7-nbits] = tx_ssdata;
                    nbits++;
                end
                prev = tx_ssclk;
            end
            check("ser_nbits", nbits, 8);
            check("ser_bits", got, cfgv);
            check("rx_pdn", rx_pdn, cfgv[0]);
        end
        bus_write(8'h10, 8'hE5);
        tick(8);
        bus_read(8'h12, rv);
        check("status_busy", rv, 8'h03);
        bus_write(8'h10, 8'h5A);
        tick(40);
        bus_read(8'h12, rv);
        check("status_idle", rv, 8'h02);
        bus_read(8'h10, rv);
        check("cfg_busy_ignored", rv, 8'hE5);

        for (int m = 0; m < 5; m++) m_duty[m] = 8'h00;
        m_mask = 5'h01; m_duty[0] = 8'h80;
        bus_write(8'h00, 8'h01); tick(4);
        bus_write(8'h01, 8'h80); tick(4);
        set_hall(0, 3'b100);
        set_hall(2, 3'b110);
        measure_and_check("m1_100");
        bus_read(8'h01, rv);
        check("duty1_rd", rv, 8'h80);
        ale = 1'b0; drv_en = 1'b1; drv = 8'h01; tick(2);
        ale = 1'b1; drv = 8'h00; tick(1);
        check("bus_hiz_read_hi", data, 8'h00);
        drv_en = 1'b0;
        set_hall(0, 3'b111);
        measure_and_check("m1_111");
        for (int r = 0; r < 2; r++) begin
            m_mask = 5'($urandom);
            bus_write(8'h00, {3'b0, m_mask}); tick(4);
            for (int m = 0; m < 5; m++) begin
                m_duty[m] = 8'($urandom);
                bus_write(8'(m + 1), m_duty[m]); tick(4);
                set_hall(m, 3'($urandom));
            end
            measure_and_check($sformatf("rnd%0d", r));
        end

        bus_write(8'h20, 8'h01); tick(4);
        check("charge_on", charge, 1'b1);
        check("ant_a0", {ant_a, ant_b}, 2'b10);
        charge_done = 1'b1; tick(4);
        check("led0", led0, 1'b1);
        bus_write(8'h21, 8'h02);
        pulse(nk, nc, bad);
        check("kick_len", nk, 2 * KU);
        check("kick_nochip", nc, 0);
        check("kick_charge_low", bad, 0);
        check("charge_back", charge, 1'b1);
        s = $urandom_range(1, 3);
        bus_write(8'h21, 8'h80 | 8'(s));
        pulse(nk, nc, bad);
        check("chip_len", nc, s * KU);
        check("chip_nokick", nk, 0);
        bus_write(8'h21, 8'h00);
        pulse(nk, nc, bad);
        check("kick_zero_str", nk + nc, 0);
        charge_done = 1'b0; tick(4);
        bus_write(8'h21, 8'h05);
        pulse(nk, nc, bad);
        check("kick_no_charge", nk + nc, 0);
        bus_write(8'h20, 8'h03); tick(4);
        check("ant_b1", {ant_a, ant_b}, 2'b01);

        sw = 4'h1; button = 1'b1;
        bus_read(8'h30, rv);
        check("inputs", rv, 8'h11);
        for (int r = 0; r < 3; r++) begin
            sw = 4'($urandom); button = 1'($urandom);
            tx_cts = 1'($urandom);
            tx_mcu = 1'($urandom); rx_radio = 1'($urandom);
            bus_read(8'h30, rv);
            check("inputs_rnd", rv, {3'b0, button, sw});
            bus_read(8'h12, rv);
            check("status_rnd", rv, {5'b0, tx_cts, 1'b1, 1'b0});
            check("uart", {tx_radio, rx_mcu}, {tx_mcu, rx_radio});
        end
        bus_read(8'h7F, rv);
        check("unmapped", rv, 8'h00);

        seq[0] = 3'b101; seq[1] = 3'b100; seq[2] = 3'b110;
        seq[3] = 3'b010; seq[4] = 3'b011; seq[5] = 3'b001;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 6; k++) set_hall(0, seq[k]);
        tick(4);
        bus_read(8'h08, rv);
`ifdef HALL_COUNTER_EN
        v = 8'(m1_changes);
`else
        v = 8'h00;
`endif
        check("hall_cnt_m1", rv, v);

        bus_write(8'h10, 8'hFF);
        tick(6);
        rst_n = 1'b0;
        #1;
        check("rst_abort_ser", {tx_ssdata, tx_ssclk, charge}, 3'b000);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        bus_read(8'h12, rv);
        check("status_after_rst", rv, {5'b0, tx_cts, 1'b1, 1'b0});
        check("gates_after_rst", gates, 30'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
